// File: rtl/avalon_tcm_responder.sv
// rtl/avalon_tcm_responder.sv - Avalon-style tightly coupled memory responder
//
// A single-port word RAM sits behind a waitrequest/response bus. The requester
// holds a command while bus_busy is high. The command is accepted in the cycle
// where bus_busy drops. Every accepted command produces exactly one response,
// LATENCY cycles after acceptance and in acceptance order. Responses cannot be
// stalled.
//
// Ports:
//   clk_i           in   1   clock, rising edge
//   rst_i           in   1   synchronous active-high reset
//   bus_read        in   1   read command
//   bus_write       in   1   write command (both high = malformed, SLAVEERROR)
//   bus_addr        in  32   byte address, bits [1:0] ignored
//   bus_be          in   4   write byte enables
//   bus_wdata       in  32   write data
//   bus_busy        out  1   waitrequest, command held while high
//   bus_rvalid      out  1   read response strobe
//   bus_rdata       out 32   read data, zero unless bus_rvalid
//   bus_wrespvalid  out  1   write response strobe
//   bus_resp        out  2   00 OKAY, 10 SLAVEERROR, 11 DECODEERROR; zero when idle
module avalon_tcm_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0,
    parameter int          LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic        bus_busy,
    output logic        bus_rvalid,
    output logic [31:0] bus_rdata,
    output logic        bus_wrespvalid,
    output logic [1:0]  bus_resp
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  WS          = 3'(WAIT_STATES);
    localparam logic [32:0] LO_ADDR     = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_ADDR     = LO_ADDR + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    logic          cmd_present;
    logic          accept;
    logic          conflict;
    logic          in_range;
    logic          do_write;
    logic          do_read;
    logic [AW-1:0] word_idx;
    logic [1:0]    cmd_code;

    logic [2:0]    wait_q;
    logic [2:0]    wait_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    // Response pipeline; stage LATENCY-1 drives the bus.
    logic [LATENCY-1:0] pv_q;
    logic [LATENCY-1:0] pw_q;
    logic [1:0]         pc_q [LATENCY];
    logic [31:0]        pd_q [LATENCY];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign cmd_present = bus_read | bus_write;
    assign bus_busy    = rst_i | (cmd_present & (wait_q != WS));
    assign accept      = cmd_present & ~bus_busy;

    // The counter counts busy cycles of the command currently offered. It
    // restarts when the command is taken or withdrawn, so a reissued command
    // waits the full WAIT_STATES again.
    always_comb begin
        wait_d = wait_q;
        if (!cmd_present || accept) begin
            wait_d = 3'd0;
        end else begin
            wait_d = wait_q + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign conflict = bus_read & bus_write;
    assign in_range = ({1'b0, bus_addr} >= LO_ADDR) && ({1'b0, bus_addr} < HI_ADDR);
    assign word_idx = AW'((bus_addr - BASE_ADDR) >> 2);
    assign do_write = accept & bus_write & ~bus_read & in_range;
    assign do_read  = accept & bus_read & ~bus_write & in_range;

    // A malformed read+write is reported as SLAVEERROR even when the address
    // also misses the window.
    always_comb begin
        cmd_code = RESP_OKAY;
        if (conflict) begin
            cmd_code = RESP_SLVERR;
        end else if (!in_range) begin
            cmd_code = RESP_DECERR;
        end
    end

    // ------------------------------------------------------------------
    // Control state: wait counter and pipeline valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q <= 3'd0;
            pv_q   <= '0;
        end else begin
            wait_q  <= wait_d;
            pv_q[0] <= accept;
            for (int k = 1; k < LATENCY; k++) begin
                pv_q[k] <= pv_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM and response payload (not reset)
    // ------------------------------------------------------------------
    // The write commits on its acceptance edge. A read accepted on the next
    // edge therefore already sees the new bytes, with no bypass needed.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= bus_wdata[8*b +: 8];
                end
            end
        end

        pw_q[0] <= bus_write & ~bus_read;
        pc_q[0] <= cmd_code;
        pd_q[0] <= do_read ? mem_q[word_idx] : 32'd0;
        for (int k = 1; k < LATENCY; k++) begin
            pw_q[k] <= pw_q[k-1];
            pc_q[k] <= pc_q[k-1];
            pd_q[k] <= pd_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gating with rst_i hides a response that would otherwise emerge during
    // the reset cycle itself. The valid bits clear on the following edge.
    assign bus_rvalid     = ~rst_i & pv_q[LATENCY-1] & ~pw_q[LATENCY-1];
    assign bus_wrespvalid = ~rst_i & pv_q[LATENCY-1] & pw_q[LATENCY-1];
    assign bus_resp       = (bus_rvalid | bus_wrespvalid) ? pc_q[LATENCY-1] : RESP_OKAY;
    assign bus_rdata      = bus_rvalid ? pd_q[LATENCY-1] : 32'd0;

endmodule

// File: tb/tb_avalon_tcm_responder.sv
// tb/tb_avalon_tcm_responder.sv - self-checking bench for avalon_tcm_responder
module tb_avalon_tcm_responder;

    localparam int          NI   = 3;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd    [NI];
    logic        wr    [NI];
    logic [31:0] addr  [NI];
    logic [3:0]  be    [NI];
    logic [31:0] wdat  [NI];
    logic        busy  [NI];
    logic        rv    [NI];
    logic [31:0] rdat  [NI];
    logic        wv    [NI];
    logic [1:0]  resp  [NI];

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: wait states. Instance 2: deep pipeline, small RAM.
    avalon_tcm_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(0), .LATENCY(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .bus_read(rd[0]), .bus_write(wr[0]), .bus_addr(addr[0]),
        .bus_be(be[0]), .bus_wdata(wdat[0]), .bus_busy(busy[0]), .bus_rvalid(rv[0]),
        .bus_rdata(rdat[0]), .bus_wrespvalid(wv[0]), .bus_resp(resp[0]));
    avalon_tcm_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(64), .WAIT_STATES(3), .LATENCY(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .bus_read(rd[1]), .bus_write(wr[1]), .bus_addr(addr[1]),
        .bus_be(be[1]), .bus_wdata(wdat[1]), .bus_busy(busy[1]), .bus_rvalid(rv[1]),
        .bus_rdata(rdat[1]), .bus_wrespvalid(wv[1]), .bus_resp(resp[1]));
    avalon_tcm_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .WAIT_STATES(0), .LATENCY(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .bus_read(rd[2]), .bus_write(wr[2]), .bus_addr(addr[2]),
        .bus_be(be[2]), .bus_wdata(wdat[2]), .bus_busy(busy[2]), .bus_rvalid(rv[2]),
        .bus_rdata(rdat[2]), .bus_wrespvalid(wv[2]), .bus_resp(resp[2]));

    function automatic int ws_of(input int i);
        return (i == 1) ? 3 : 0;
    endfunction
    function automatic int lat_of(input int i);
        return i + 1;
    endfunction
    function automatic int depth_of(input int i);
        return (i == 0) ? 1024 : ((i == 1) ? 64 : 16);
    endfunction

    typedef struct {
        int          inst;
        int          due;
        bit          is_wr;
        logic [1:0]  code;
        logic [31:0] data;
        logic [31:0] mask;
    } rsp_t;

    typedef struct {
        int          inst;
        int          cyc;
        bit          is_wr;
        logic [1:0]  code;
        logic [31:0] data;
    } obs_t;

    rsp_t        exp_q[$];
    obs_t        obs_q[$];
    logic [31:0] mmem   [NI][1024];
    bit   [3:0]  mknown [NI][1024];
    int          wcnt     [NI];
    bit          acc_flag [NI];
    int          acc_cyc  [NI];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference behaviour of one accepted command: decode, memory effect, response.
    task automatic model_accept(input int i, input int cur);
        rsp_t   r;
        longint lo;
        longint hi;
        longint a;
        int     idx;
        lo      = longint'(BASE);
        hi      = lo + 4 * depth_of(i);
        a       = longint'(addr[i]);
        r.inst  = i;
        r.due   = cur + lat_of(i);
        r.data  = 32'd0;
        r.mask  = 32'hFFFF_FFFF;
        r.code  = 2'b00;
        r.is_wr = wr[i] && !rd[i];
        if (rd[i] && wr[i]) begin
            r.code = 2'b10;
        end else if (a < lo || a >= hi) begin
            r.code = 2'b11;
        end else begin
            idx = int'((a - lo) / 4);
            if (wr[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[i][b]) begin
                        mmem[i][idx][8*b +: 8] = wdat[i][8*b +: 8];
                        mknown[i][idx][b]      = 1'b1;
                    end
                end
            end else begin
                r.data = mmem[i][idx];
                for (int b = 0; b < 4; b++) begin
                    r.mask[8*b +: 8] = mknown[i][idx][b] ? 8'hFF : 8'h00;
                end
            end
        end
        exp_q.push_back(r);
    endtask

    // Model: sees the inputs of each cycle at its rising edge.
    initial forever begin
        int cur;
        @(posedge clk);
        cur = cyc;
        for (int i = 0; i < NI; i++) begin
            acc_flag[i] = 1'b0;
            if (rst) begin
                wcnt[i] = 0;
            end else if (rd[i] || wr[i]) begin
                if (wcnt[i] == ws_of(i)) begin
                    wcnt[i]     = 0;
                    acc_flag[i] = 1'b1;
                    acc_cyc[i]  = cur + 1;
                    model_accept(i, cur);
                end else begin
                    wcnt[i]++;
                end
            end else begin
                wcnt[i] = 0;
            end
        end
        if (rst) exp_q.delete();
        cyc = cur + 1;
    end

    // Compare: every cycle, every instance, away from the active edge.
    initial forever begin
        int   pos;
        rsp_t e;
        bit   exp_busy;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            pos = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].inst == i) begin
                    pos = k;
                    break;
                end
            end
            exp_busy = rst || ((rd[i] || wr[i]) && (wcnt[i] != ws_of(i)));
            check($sformatf("busy[%0d] cyc%0d", i, cyc), 32'(busy[i]), 32'(exp_busy));
            if (!rst && pos >= 0 && exp_q[pos].due == cyc) begin
                e = exp_q[pos];
                exp_q.delete(pos);
                check($sformatf("rvalid[%0d] cyc%0d", i, cyc), 32'(rv[i]), 32'(!e.is_wr));
                check($sformatf("wrespvalid[%0d] cyc%0d", i, cyc), 32'(wv[i]), 32'(e.is_wr));
                check($sformatf("resp[%0d] cyc%0d", i, cyc), 32'(resp[i]), 32'(e.code));
                check($sformatf("rdata[%0d] cyc%0d", i, cyc), rdat[i] & e.mask, e.data & e.mask);
            end else begin
                check($sformatf("idle_rvalid[%0d] cyc%0d", i, cyc), 32'(rv[i]), 32'd0);
                check($sformatf("idle_wresp[%0d] cyc%0d", i, cyc), 32'(wv[i]), 32'd0);
                check($sformatf("idle_resp[%0d] cyc%0d", i, cyc), 32'(resp[i]), 32'd0);
                check($sformatf("idle_rdata[%0d] cyc%0d", i, cyc), rdat[i], 32'd0);
            end
            if (rv[i] || wv[i]) obs_q.push_back(obs_t'{i, cyc, wv[i], resp[i], rdat[i]});
        end
    end

    task automatic set_cmd(input int i, input logic r, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        rd[i] = r; wr[i] = w; addr[i] = a; be[i] = b; wdat[i] = d;
    endtask

    // Offer a command and hold it until accepted. Returns the acceptance cycle.
    task automatic issue(input int i, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, output int acc);
        set_cmd(i, r, w, a, b, d);
        acc = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (acc_flag[i]) begin
                acc = acc_cyc[i];
                break;
            end
        end
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout[%0d]: not accepted within 40 cycles", i);
        end
        rd[i] = 1'b0;
        wr[i] = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int count_obs(input int i, input bit rd_only);
        int c = 0;
        foreach (obs_q[k]) if (obs_q[k].inst == i && !(rd_only && obs_q[k].is_wr)) c++;
        return c;
    endfunction

    function automatic obs_t nth_obs(input int i, input bit rd_only, input int n);
        obs_t o = '{-1, -1, 1'b0, 2'b00, 32'd0};
        int   c = 0;
        foreach (obs_q[k]) begin
            if (obs_q[k].inst == i && !(rd_only && obs_q[k].is_wr)) begin
                if (c == n) return obs_q[k];
                c++;
            end
        end
        return o;
    endfunction

    task automatic count_busy(input int i, output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy[i]) n++;
            else break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a0, a1, a2, a3, c0, n;
        obs_t o;
        int   ra [4];

        rst = 1'b1;
        for (int i = 0; i < NI; i++) set_cmd(i, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        wait_cycles(3);
        set_cmd(0, 1'b1, 1'b0, BASE, 4'hF, 32'd0);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check($sformatf("reset_busy[%0d]", i), 32'(busy[i]), 32'd1);
        check("reset_rvalid", 32'(rv[0]), 32'd0);
        check("reset_resp", 32'(resp[0]), 32'd0);
        @(posedge clk); #1;
        rd[0] = 1'b0;
        rst = 1'b0;

        // Acceptance right after reset, then write + read-next-cycle.
        c0 = cyc;
        obs_q.delete();
        issue(0, 1'b0, 1'b1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF, a0);
        check("first_accept_after_reset", 32'(a0 - c0), 32'd1);
        issue(0, 1'b1, 1'b0, 32'h0001_0010, 4'h0, 32'd0, a1);
        check("read_next_cycle", 32'(a1 - a0), 32'd1);
        wait_cycles(4);
        check("t1_count", 32'(count_obs(0, 1'b0)), 32'd2);
        o = nth_obs(0, 1'b0, 0);
        check("t1_wresp_flag", 32'(o.is_wr), 32'd1);
        check("t1_wresp_latency", 32'(o.cyc - a0), 32'd0);
        check("t1_wresp_code", 32'(o.code), 32'd0);
        o = nth_obs(0, 1'b0, 1);
        check("t1_read_latency", 32'(o.cyc - a1), 32'd0);
        check("t1_read_data", o.data, 32'hDEAD_BEEF);
        check("t1_read_code", 32'(o.code), 32'd0);

        // Byte-enable merge.
        obs_q.delete();
        issue(0, 1'b0, 1'b1, 32'h0001_0020, 4'hF, 32'h1122_3344, a0);
        issue(0, 1'b0, 1'b1, 32'h0001_0020, 4'h5, 32'hAABB_CCDD, a0);
        issue(0, 1'b1, 1'b0, 32'h0001_0020, 4'h0, 32'd0, a0);
        wait_cycles(3);
        o = nth_obs(0, 1'b1, 0);
        check("t2_merge", o.data, 32'h11BB_33DD);

        // Decode errors, boundaries, malformed command.
        obs_q.delete();
        issue(0, 1'b1, 1'b0, 32'h0002_0000, 4'h0, 32'd0, a0);
        issue(0, 1'b0, 1'b1, 32'h0000_FFFC, 4'hF, 32'h1234_5678, a0);
        issue(0, 1'b1, 1'b1, 32'h0001_0010, 4'hF, 32'h0000_0000, a0);
        issue(0, 1'b1, 1'b0, 32'h0001_0010, 4'h0, 32'd0, a0);
        issue(0, 1'b1, 1'b0, 32'h0001_0FFC, 4'h0, 32'd0, a0);
        issue(0, 1'b1, 1'b0, 32'h0001_1000, 4'h0, 32'd0, a0);
        wait_cycles(3);
        check("t3_count", 32'(count_obs(0, 1'b0)), 32'd6);
        o = nth_obs(0, 1'b0, 0);
        check("t3_oor_read_code", 32'(o.code), 32'd3);
        check("t3_oor_read_data", o.data, 32'd0);
        o = nth_obs(0, 1'b0, 1);
        check("t3_oor_write_flag", 32'(o.is_wr), 32'd1);
        check("t3_oor_write_code", 32'(o.code), 32'd3);
        o = nth_obs(0, 1'b0, 2);
        check("t3_both_is_read", 32'(o.is_wr), 32'd0);
        check("t3_both_code", 32'(o.code), 32'd2);
        check("t3_both_data", o.data, 32'd0);
        o = nth_obs(0, 1'b0, 3);
        check("t3_mem_unchanged", o.data, 32'hDEAD_BEEF);
        o = nth_obs(0, 1'b0, 4);
        check("t3_last_word_code", 32'(o.code), 32'd0);
        o = nth_obs(0, 1'b0, 5);
        check("t3_past_end_code", 32'(o.code), 32'd3);

        // Wait states, and withdrawal restarting the count.
        set_cmd(1, 1'b1, 1'b0, BASE, 4'h0, 32'd0);
        count_busy(1, n);
        check("t4_busy_cycles", 32'(n), 32'd3);
        @(posedge clk); #1;
        rd[1] = 1'b0;
        set_cmd(1, 1'b1, 1'b0, BASE + 32'd4, 4'h0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rd[1] = 1'b0;
        @(posedge clk); #1;
        rd[1] = 1'b1;
        count_busy(1, n);
        check("t4_busy_after_withdraw", 32'(n), 32'd3);
        @(posedge clk); #1;
        rd[1] = 1'b0;
        wait_cycles(4);

        // Back-to-back reads through a 3-deep pipeline.
        for (int k = 0; k < 4; k++) issue(2, 1'b0, 1'b1, BASE + 32'(4 * k), 4'hF, 32'(k), a0);
        wait_cycles(4);
        obs_q.delete();
        for (int k = 0; k < 4; k++) issue(2, 1'b1, 1'b0, BASE + 32'(4 * k), 4'h0, 32'd0, ra[k]);
        wait_cycles(6);
        check("t5_count", 32'(count_obs(2, 1'b1)), 32'd4);
        for (int k = 0; k < 4; k++) begin
            o = nth_obs(2, 1'b1, k);
            check($sformatf("t5_accept_b2b%0d", k), 32'(ra[k] - ra[0]), 32'(k));
            check($sformatf("t5_data%0d", k), o.data, 32'(k));
            check($sformatf("t5_cycle%0d", k), 32'(o.cyc - ra[0]), 32'(k + 2));
        end

        // Reset with responses in flight; an earlier write must persist.
        obs_q.delete();
        issue(2, 1'b0, 1'b1, BASE + 32'd20, 4'hF, 32'hCAFE_0005, a0);
        issue(2, 1'b1, 1'b0, BASE, 4'h0, 32'd0, a1);
        issue(2, 1'b1, 1'b0, BASE + 32'd4, 4'h0, 32'd0, a2);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check($sformatf("t6_busy_in_reset[%0d]", i), 32'(busy[i]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cycles(6);
        check("t6_no_responses", 32'(count_obs(2, 1'b0)), 32'd0);
        issue(2, 1'b1, 1'b0, BASE + 32'd20, 4'h0, 32'd0, a3);
        wait_cycles(5);
        check("t6_count_after", 32'(count_obs(2, 1'b1)), 32'd1);
        o = nth_obs(2, 1'b1, 0);
        check("t6_write_survived", o.data, 32'hCAFE_0005);
        check("t6_latency", 32'(o.cyc - a3), 32'd2);

        // Randomized traffic on all instances, with occasional withdrawal and reset.
        for (int n2 = 0; n2 < 3000; n2++) begin
            for (int i = 0; i < NI; i++) begin
                if ((rd[i] || wr[i]) && !acc_flag[i]) begin
                    if ($urandom_range(0, 15) == 0) begin
                        rd[i] = 1'b0;
                        wr[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    rd[i] = 1'b0;
                    wr[i] = 1'b0;
                end else begin
                    int unsigned kind;
                    int unsigned sel;
                    logic [31:0] a;
                    int          lim;
                    kind = $urandom_range(0, 9);
                    sel  = $urandom_range(0, 9);
                    lim  = (depth_of(i) < 32) ? depth_of(i) : 32;
                    case (sel)
                        0:       a = BASE - 32'd4;
                        1:       a = BASE + 32'(4 * depth_of(i));
                        2:       a = BASE + 32'(4 * (depth_of(i) - 1)) + 32'($urandom_range(0, 3));
                        3:       a = $urandom;
                        default: a = BASE + 32'(4 * $urandom_range(0, lim - 1)) + 32'($urandom_range(0, 3));
                    endcase
                    set_cmd(i, kind <= 4, kind == 0 || kind >= 5, a, 4'($urandom), $urandom);
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int i = 0; i < NI; i++) set_cmd(i, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        wait_cycles(10);
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_tcm_responder.md
AVALON_TCM_RESPONDER -- requirements
Module: avalon_tcm_responder

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h0001_0000: byte address of word 0.
REQ-002 SHALL provide parameter DEPTH_WORDS, default 1024: RAM size in 32-bit words (power of two, 16..16384).
REQ-003 SHALL provide parameter WAIT_STATES, default 0: bus_busy cycles inserted per command (0..7).
REQ-004 SHALL provide parameter LATENCY, default 1: cycles from command acceptance to response (1..4).
REQ-005 SHALL provide clk_i, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL provide rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL provide bus_read, input, 1: read command.
REQ-008 SHALL provide bus_write, input, 1: write command.
REQ-009 SHALL provide bus_addr, input, 32: byte address; bits [1:0] ignored.
REQ-010 SHALL provide bus_be, input, 4: write byte enables.
REQ-011 SHALL provide bus_wdata, input, 32: write data.
REQ-012 SHALL provide bus_busy, output, 1: waitrequest; the command is not accepted while high.
REQ-013 SHALL provide bus_rvalid, output, 1: read response strobe.
REQ-014 SHALL provide bus_rdata, output, 32: read data, valid with bus_rvalid.
REQ-015 SHALL provide bus_wrespvalid, output, 1: write response strobe.
REQ-016 SHALL provide bus_resp, output, 2: response code, valid with either strobe: 00 OKAY, 10 SLAVEERROR, 11 DECODEERROR.

Function
REQ-017 SHALL treat a command as present when bus_read|bus_write, and as accepted in a cycle where it is present and bus_busy=0.
REQ-018 SHALL drive bus_busy = 1 during rst_i; otherwise bus_busy = command present & (wait counter != WAIT_STATES); WAIT_STATES=0 gives zero-wait acceptance.
REQ-019 SHALL operate a 3-bit wait counter: reset to 0; increment on each present-and-busy cycle; clear to 0 on acceptance; clear to 0 when the command is withdrawn before acceptance.
REQ-020 SHALL decode in range iff BASE_ADDR <= bus_addr < BASE_ADDR + 4*DEPTH_WORDS, with word index = (bus_addr - BASE_ADDR) >> 2.
REQ-021 SHALL, for an accepted in-range write, update only the bytes whose bus_be bit is set, in the acceptance cycle; bus_be=0000 gives OKAY with no change.
REQ-022 SHALL, for an accepted in-range read, return the word as it stands after all previously accepted writes, including a write accepted in the immediately preceding cycle.
REQ-023 SHALL, for an out-of-range command, leave memory unmodified, respond with code 11, and return bus_rdata = 0 for reads.
REQ-024 SHALL, when bus_read and bus_write are both high, accept the command as a read with code 10, bus_rdata = 0, and no memory update.
REQ-025 SHALL emit exactly one response per accepted command, exactly LATENCY cycles after the acceptance edge, through a LATENCY-deep response shift pipeline of {valid, is_write, code, data}.
REQ-026 SHALL return responses in acceptance order; back-to-back acceptance every cycle gives back-to-back responses with no bubbles and no response backpressure.
REQ-027 SHALL never assert bus_rvalid and bus_wrespvalid in the same cycle.
REQ-028 SHALL hold bus_rdata and bus_resp at 0 whenever no strobe is asserted.

Reset
REQ-029 SHALL, on rst_i, clear the wait counter and all pipeline valid bits the next cycle, so bus_rvalid=0, bus_wrespvalid=0, bus_resp=00, bus_rdata=0 and bus_busy=1 during reset.
REQ-030 SHALL discard responses in flight when reset is asserted mid-operation, and SHALL complete any write accepted before reset.
REQ-031 SHALL not initialise RAM contents on reset.
REQ-032 SHALL accept commands from the first cycle after rst_i deasserts (subject to WAIT_STATES).

Verification
REQ-033 Defaults: write 0xDEADBEEF to 0x0001_0010 with be=1111, then read it on the next cycle -> wrespvalid/resp=00 at acceptance+1; rvalid, rdata=0xDEADBEEF, resp=00 one cycle after the read is accepted.
REQ-034 Write 0x11223344 with be=1111, then 0xAABBCCDD with be=0101 to the same address, then read it -> rdata=0x11BB33DD.
REQ-035 WAIT_STATES=3, hold a read -> bus_busy high for exactly 3 cycles, acceptance in the 4th cycle; withdraw the read after 2 busy cycles and reissue it -> counter restarts at 0 and gives 3 busy cycles again.
REQ-036 LATENCY=3, issue reads on 4 consecutive cycles to words 0..3 preloaded with 0..3 -> 4 consecutive rvalid cycles starting 3 cycles after the first acceptance, with rdata 0,1,2,3.
REQ-037 Read 0x0002_0000 and write 0x0000_FFFC -> resp=11, rdata=0, memory unchanged; read and write high together -> rvalid with resp=10.
REQ-038 Assert rst_i for 1 cycle while 2 reads are in flight (LATENCY=3) -> no rvalid pulses occur; busy=1 during reset; a read issued after reset returns correct data.
